// File: rtl/adc_spi_capture_pkg.sv
// adc_spi_capture_pkg: shared Q-format defaults and capture FSM states
package adc_spi_capture_pkg;
    localparam int def_largo = 24;
    localparam int def_mag   = 8;
    localparam int def_pres  = 16;
    localparam logic signed [def_largo:0] q_one = 1 <<< def_pres;
    typedef enum logic [1:0] {st_idle, st_shift, st_done} cap_state_t;
endpackage

// File: rtl/adc_spi_capture_sample_tick_gen.sv
// sample_tick_gen: free-running 0..sample_per-1 counter, tick pulses the clk after wrap
module sample_tick_gen #(
    parameter int sample_per = 2500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int cw = $clog2(sample_per);
    localparam logic [cw-1:0] last = cw'(sample_per - 1);
    logic [cw-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == last) ? '0 : cnt + 1'b1;
            tick <= (cnt == last);
        end
    end
endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: drives a 12-bit offset-binary SPI ADC and emits signed Q(mag).(pres) samples
module adc_spi_capture
    import adc_spi_capture_pkg::*;
#(
    parameter int largo      = def_largo,
    parameter int mag        = def_mag,
    parameter int pres       = def_pres,
    parameter int div        = 2,
    parameter int sample_per = 2500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdata_i,
    output logic             cs_n_o,
    output logic             sclk_o,
    output logic [largo:0]   data_o,
    output logic             data_valid_o,
    output logic             overrun_o
);
    localparam int pw = $clog2(2 * div);
    localparam logic [pw-1:0] ph_rise = pw'(div);
    localparam logic [pw-1:0] ph_last = pw'(2 * div - 1);

    if (pres < 11 || mag + pres != largo) begin : g_fmt_bad
        $error("adc_spi_capture: inconsistent Q format");
    end

    cap_state_t state, state_n;
    logic tick;
    logic [pw-1:0] phase;
    logic [3:0] bit_cnt;
    logic [11:0] sr;
    logic signed [11:0] s;
    logic signed [largo:0] conv;
    logic [largo:0] data_q;
    logic last_bit;

    sample_tick_gen #(.sample_per(sample_per)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    // only 12 bits are kept: the 4 leading frame bits shift out the top
    assign s = {~sr[11], sr[10:0]};
    assign conv = {{(largo - 11){s[11]}}, s} <<< (pres - 11);
    assign last_bit = (bit_cnt == 4'd15) && (phase == ph_last);

    always_comb begin
        state_n = state;
        if (state == st_idle && tick) state_n = st_shift;
        else if (state == st_shift && last_bit) state_n = st_done;
        else if (state == st_done) state_n = st_idle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= st_idle;
            phase   <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            data_q  <= '0;
        end else begin
            state <= state_n;
            if (state == st_shift) begin
                phase <= (phase == ph_last) ? '0 : phase + 1'b1;
                if (phase == ph_last) bit_cnt <= bit_cnt + 1'b1;
                if (phase == ph_rise) sr <= {sr[10:0], sdata_i};
            end else begin
                phase   <= '0;
                bit_cnt <= '0;
            end
            if (state == st_done) data_q <= conv;
        end
    end

    assign cs_n_o       = (state != st_shift);
    assign sclk_o       = !(state == st_shift && phase < ph_rise);
    assign data_valid_o = (state == st_done);
    assign overrun_o    = tick && (state != st_idle);
    assign data_o       = data_valid_o ? conv : data_q;
endmodule
